// File: rtl/wbgpio_irq.sv
// Wishbone GPIO with per-bit direction, atomic set/clear and masked edge interrupts.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module wbgpio_irq #(
  parameter int              NIO         = 16,
  parameter logic [NIO-1:0]  DEFAULT_OUT = {NIO{1'b0}},
  parameter logic [NIO-1:0]  DEFAULT_DIR = {NIO{1'b0}},
  parameter int              DEBOUNCE_LG = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [2:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  input  logic [3:0]      i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  input  logic [NIO-1:0]  i_gpio,
  output logic [NIO-1:0]  o_gpio,
  output logic [NIO-1:0]  o_gpio_oe,
  output logic            o_int
);

  localparam logic [2:0] A_IN   = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_SET  = 3'd2;
  localparam logic [2:0] A_CLR  = 3'd3;
  localparam logic [2:0] A_DIR  = 3'd4;
  localparam logic [2:0] A_RISE = 3'd5;
  localparam logic [2:0] A_FALL = 3'd6;
  localparam logic [2:0] A_STAT = 3'd7;

  logic [NIO-1:0] out_r, dir_r, rise_en_r, fall_en_r, stat_r;
  logic [NIO-1:0] sync1_r, sync2_r, prev_r, in_val_s;
  logic [NIO-1:0] rise_s, fall_s, w1c_s, wmask_s, wdata_s, rsel_s;
  logic [31:0]    bmask_s, rdata_s, rdata_r;
  logic           wr_s, ack_r, int_r;
  logic           unused_s;

  assign bmask_s  = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign wmask_s  = bmask_s[NIO-1:0];
  assign wdata_s  = i_wb_data[NIO-1:0] & wmask_s;
  assign wr_s     = i_wb_stb & i_wb_we;
  assign unused_s = ^{i_wb_cyc, i_wb_data, bmask_s};

  // Pad synchroniser and previous-value register; reset loads the pad so no spurious edge appears.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_r <= i_gpio;
      sync2_r <= i_gpio;
      prev_r  <= i_gpio;
    end else begin
      sync1_r <= i_gpio;
      sync2_r <= sync1_r;
      prev_r  <= in_val_s;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [NIO-1:0]         filt_r;
  logic [DEBOUNCE_LG-1:0] cnt_r [NIO];

  // Per-bit filter: follow the synchronised input only after it has differed for 2^DEBOUNCE_LG clocks.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      filt_r <= i_gpio;
      for (int i = 0; i < NIO; i++) begin
        cnt_r[i] <= {DEBOUNCE_LG{1'b0}};
      end
    end else begin
      for (int i = 0; i < NIO; i++) begin
        if (sync2_r[i] != filt_r[i]) begin
          if (cnt_r[i] == {DEBOUNCE_LG{1'b1}}) begin
            filt_r[i] <= sync2_r[i];
            cnt_r[i]  <= {DEBOUNCE_LG{1'b0}};
          end else begin
            cnt_r[i]  <= cnt_r[i] + DEBOUNCE_LG'(1);
          end
        end else begin
          cnt_r[i] <= {DEBOUNCE_LG{1'b0}};
        end
      end
    end
  end

  assign in_val_s = filt_r;
`else
  localparam int unused_debounce_lg = DEBOUNCE_LG;
  assign in_val_s = sync2_r;
`endif

  assign rise_s = in_val_s & ~prev_r;
  assign fall_s = ~in_val_s & prev_r;

  // Write-1-to-clear mask for the status register.
  always_comb begin
    w1c_s = {NIO{1'b0}};
    if (wr_s && (i_wb_addr == A_STAT)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = {NIO{1'b0}};
    end
  end

  // Control registers and sticky status; a new edge wins over a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_r     <= DEFAULT_OUT;
      dir_r     <= DEFAULT_DIR;
      rise_en_r <= {NIO{1'b0}};
      fall_en_r <= {NIO{1'b0}};
      stat_r    <= {NIO{1'b0}};
    end else begin
      stat_r <= (stat_r & ~w1c_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
      if (wr_s) begin
        case (i_wb_addr)
          A_OUT:   out_r     <= (out_r & ~wmask_s) | wdata_s;
          A_SET:   out_r     <= out_r | wdata_s;
          A_CLR:   out_r     <= out_r & ~wdata_s;
          A_DIR:   dir_r     <= (dir_r & ~wmask_s) | wdata_s;
          A_RISE:  rise_en_r <= (rise_en_r & ~wmask_s) | wdata_s;
          A_FALL:  fall_en_r <= (fall_en_r & ~wmask_s) | wdata_s;
          default: out_r     <= out_r;
        endcase
      end
    end
  end

  // Read multiplexer, zero-extended to the bus width.
  always_comb begin
    rsel_s  = {NIO{1'b0}};
    rdata_s = 32'h0;
    case (i_wb_addr)
      A_IN:    rsel_s = in_val_s;
      A_OUT:   rsel_s = out_r;
      A_SET:   rsel_s = out_r;
      A_CLR:   rsel_s = out_r;
      A_DIR:   rsel_s = dir_r;
      A_RISE:  rsel_s = rise_en_r;
      A_FALL:  rsel_s = fall_en_r;
      A_STAT:  rsel_s = stat_r;
      default: rsel_s = {NIO{1'b0}};
    endcase
    rdata_s[NIO-1:0] = rsel_s;
  end

  // Bus response and interrupt line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'h0;
      int_r   <= 1'b0;
    end else begin
      ack_r <= i_wb_stb;
      int_r <= |stat_r;
      if (i_wb_stb) begin
        rdata_r <= rdata_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_r;
  assign o_wb_data  = rdata_r;
  assign o_gpio     = out_r;
  assign o_gpio_oe  = dir_r;
  assign o_int      = int_r;

endmodule

// File: tb/tb_wbgpio_irq.sv
// Directed self-checking bench for wbgpio_irq (NIO=16, DEFAULT_OUT=00A5, DEFAULT_DIR=00FF).
module tb_wbgpio_irq;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [2:0]  i_wb_addr = 3'd0;
  logic [31:0] i_wb_data = 32'h0;
  logic [3:0]  i_wb_sel = 4'hF;
  logic        o_wb_stall, o_wb_ack, o_int;
  logic [31:0] o_wb_data;
  logic [15:0] i_gpio = 16'h0000;
  logic [15:0] o_gpio, o_gpio_oe;

  int checks = 0;
  int errors = 0;

`ifdef GPIO_DEBOUNCE_EN
  localparam int DLAT = 16;
`else
  localparam int DLAT = 0;
`endif

  wbgpio_irq #(
    .NIO(16), .DEFAULT_OUT(16'h00A5), .DEFAULT_DIR(16'h00FF), .DEBOUNCE_LG(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .i_gpio(i_gpio), .o_gpio(o_gpio), .o_gpio_oe(o_gpio_oe), .o_int(o_int)
  );

  always #5 i_clk = ~i_clk;

  // One single-cycle strobe; returns ack and data sampled just after the following edge.
  task automatic bus(input logic [2:0] a, input logic we, input logic [31:0] d,
                     input logic [3:0] sel, output logic ack, output logic [31:0] rd);
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = a; i_wb_data = d; i_wb_sel = sel;
    @(posedge i_clk); #1;
    ack = o_wb_ack; rd = o_wb_data;
    i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
  endtask

  task automatic test_reset;
    logic ack; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_int !== 1'b0 || o_wb_ack !== 1'b0) begin
        errors++; $display("FAIL reset_outputs int=%b ack=%b required 0 0", o_int, o_wb_ack);
      end
    end
    checks++;
    if (o_gpio !== 16'h00A5 || o_gpio_oe !== 16'h00FF || o_wb_stall !== 1'b0) begin
      errors++; $display("FAIL reset_pins gpio=%h oe=%h stall=%b required 00a5 00ff 0", o_gpio, o_gpio_oe, o_wb_stall);
    end
    @(negedge i_clk); i_reset = 1'b0;
    bus(3'd1, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (ack !== 1'b1 || rd !== 32'h000000A5) begin
      errors++; $display("FAIL reset_out ack=%b data=%h required 1 000000a5", ack, rd);
    end
    bus(3'd4, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h000000FF) begin
      errors++; $display("FAIL reset_dir data=%h required 000000ff", rd);
    end
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h0 || o_int !== 1'b0) begin
      errors++; $display("FAIL reset_stat data=%h int=%b required 0 0", rd, o_int);
    end
  endtask

  task automatic test_set_clr;
    logic ack; logic [31:0] rd;
    logic [31:0] wv [3] = '{32'h0F0F, 32'h3000, 32'h0003};
    logic [15:0] ev [3] = '{16'h0F0F, 16'h3F0F, 16'h3F0C};
    for (int i = 0; i < 3; i++) begin
      bus(3'(i + 1), 1'b1, wv[i], 4'hF, ack, rd);
      @(negedge i_clk);
      checks++;
      if (ack !== 1'b1 || o_gpio !== ev[i]) begin
        errors++; $display("FAIL set_clr_%0d ack=%b gpio=%h required 1 %h", i, ack, o_gpio, ev[i]);
      end
    end
    bus(3'd2, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h00003F0C) begin
      errors++; $display("FAIL set_readback data=%h required 00003f0c", rd);
    end
  endtask

  task automatic test_byte_sel;
    logic ack; logic [31:0] rd;
    bus(3'd1, 1'b1, 32'h1234, 4'hF, ack, rd);
    bus(3'd1, 1'b1, 32'hFFFF, 4'b0001, ack, rd);
    bus(3'd1, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h000012FF) begin
      errors++; $display("FAIL byte_sel data=%h required 000012ff", rd);
    end
    bus(3'd4, 1'b1, 32'hFFFFFFFF, 4'hF, ack, rd);
    bus(3'd4, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h0000FFFF || o_gpio_oe !== 16'hFFFF) begin
      errors++; $display("FAIL upper_bits data=%h oe=%h required 0000ffff ffff", rd, o_gpio_oe);
    end
  endtask

  task automatic test_rise;
    logic ack; logic [31:0] rd;
    bus(3'd5, 1'b1, 32'h1, 4'hF, ack, rd);
    @(negedge i_clk); i_gpio[0] = 1'b1;
    repeat (3 + DLAT) @(posedge i_clk);
    #1;
    checks++;
    if (o_int !== 1'b0) begin
      errors++; $display("FAIL rise_int_early int=%b required 0", o_int);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_int !== 1'b1) begin
      errors++; $display("FAIL rise_int int=%b required 1", o_int);
    end
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL rise_stat data=%h required 00000001", rd);
    end
    bus(3'd7, 1'b1, 32'h1, 4'hF, ack, rd);
    checks++;
    if (o_int !== 1'b1) begin
      errors++; $display("FAIL w1c_int_hold int=%b required 1", o_int);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_int !== 1'b0) begin
      errors++; $display("FAIL w1c_int_drop int=%b required 0", o_int);
    end
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL w1c_stat data=%h required 0", rd);
    end
  endtask

  task automatic test_fall_coincide;
    logic ack; logic [31:0] rd;
    bus(3'd6, 1'b1, 32'h2, 4'hF, ack, rd);
    @(negedge i_clk); i_gpio[1] = 1'b1; i_gpio[2] = 1'b1;
    repeat (6 + DLAT) @(posedge i_clk);
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL disabled_edges data=%h required 0", rd);
    end
    @(negedge i_clk); i_gpio[1] = 1'b0;
    repeat (2 + DLAT) @(posedge i_clk);
    bus(3'd7, 1'b1, 32'h2, 4'hF, ack, rd);
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL fall_w1c_coincide data=%h required 00000002", rd);
    end
    bus(3'd6, 1'b1, 32'h0, 4'hF, ack, rd);
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h2 || o_int !== 1'b1) begin
      errors++; $display("FAIL enable_clear_keeps data=%h int=%b required 00000002 1", rd, o_int);
    end
    bus(3'd7, 1'b1, 32'h2, 4'hF, ack, rd);
    bus(3'd0, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++; $display("FAIL in_read data=%h required 00000005", rd);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = 3'd1; i_wb_data = 32'hAAAA; i_wb_sel = 4'hF;
    @(posedge i_clk); #1;
    checks++;
    if (o_wb_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_ack0 ack=%b required 1", o_wb_ack);
    end
    i_wb_we = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_wb_ack !== 1'b1 || o_wb_data !== 32'h0000AAAA) begin
      errors++; $display("FAIL b2b_ack1 ack=%b data=%h required 1 0000aaaa", o_wb_ack, o_wb_data);
    end
    i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_wb_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_idle ack=%b required 0", o_wb_ack);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 3'd1; i_reset = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_wb_ack !== 1'b0 || o_wb_data !== 32'h0 || o_gpio !== 16'h00A5 || o_int !== 1'b0) begin
      errors++; $display("FAIL reset_mid ack=%b data=%h gpio=%h int=%b required 0 0 00a5 0",
                         o_wb_ack, o_wb_data, o_gpio, o_int);
    end
    i_wb_stb = 1'b0;
    @(negedge i_clk); i_reset = 1'b0;
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    logic ack; logic [31:0] rd;
    bus(3'd5, 1'b1, 32'h8, 4'hF, ack, rd);
    @(negedge i_clk); i_gpio[3] = 1'b1;
    repeat (10) @(negedge i_clk);
    i_gpio[3] = 1'b0;
    repeat (30) @(posedge i_clk);
    bus(3'd0, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd[3] !== 1'b0) begin
      errors++; $display("FAIL glitch_in bit3=%b required 0", rd[3]);
    end
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd[3] !== 1'b0) begin
      errors++; $display("FAIL glitch_stat bit3=%b required 0", rd[3]);
    end
    @(negedge i_clk); i_gpio[3] = 1'b1;
    repeat (25) @(posedge i_clk);
    bus(3'd0, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd[3] !== 1'b1) begin
      errors++; $display("FAIL level_in bit3=%b required 1", rd[3]);
    end
    bus(3'd7, 1'b0, 32'h0, 4'hF, ack, rd);
    checks++;
    if (rd[3] !== 1'b1) begin
      errors++; $display("FAIL level_stat bit3=%b required 1", rd[3]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_set_clr();
    test_byte_sel();
    test_rise();
    test_fall_coincide();
    test_back_to_back();
    test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
